// File: rtl/fdiv_issue_unit.sv
// Request FIFO and issue sequencer in front of the Newton-iteration divider.
// Holds operands/fdiv for one division at a time, returns tagged results, aborts on timeout.
module fdiv_issue_unit #(
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    clr_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [31:0]             req_a_i,
  input  logic [31:0]             req_b_i,
  input  logic [1:0]              req_rm_i,
  input  logic [TAG_W-1:0]        req_tag_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_s_o,
  output logic [TAG_W-1:0]        rsp_tag_o,
  output logic                    rsp_err_o,
  output logic [31:0]             div_a_o,
  output logic [31:0]             div_b_o,
  output logic [1:0]              div_rm_o,
  output logic                    div_fdiv_o,
  output logic                    div_ena_o,
  input  logic [31:0]             div_s_i,
  input  logic                    div_busy_i,
  output logic [$clog2(DEPTH):0]  q_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [31:0] QNAN = 32'h7fc0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;

  logic [31:0]       a_mem   [DEPTH];
  logic [31:0]       b_mem   [DEPTH];
  logic [1:0]        rm_mem  [DEPTH];
  logic [TAG_W-1:0]  tag_mem [DEPTH];

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              fdiv_q, fdiv_d;
  logic              ena_q;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [31:0]       rsp_s_q, rsp_s_d;
  logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;

  logic              push, pop, issue, timeout, done;

  assign req_ready_o = (count_q < CW'(DEPTH));
  assign push        = req_valid_i & req_ready_o;
  // Issue only when the response slot is free or being drained this cycle.
  assign issue       = (state_q == S_IDLE) && (count_q != '0) && (!rsp_valid_q || rsp_ready_i);
  assign timeout     = (state_q != S_IDLE) && (timer_q == TW'(TIMEOUT - 1));
  assign done        = (state_q == S_WAIT) && !div_busy_i;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (issue) state_d = S_ISSUE;
      S_ISSUE: begin
        if (timeout)         state_d = S_IDLE;
        else if (div_busy_i) state_d = S_WAIT;
      end
      S_WAIT:  if (timeout || done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop         = timeout | done;
    fdiv_d      = (state_d != S_IDLE);
    timer_d     = timer_q;
    rsp_valid_d = rsp_valid_q;
    rsp_s_d     = rsp_s_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    count_d     = count_q;

    if (issue)                  timer_d = '0;
    else if (state_q != S_IDLE) timer_d = timer_q + 1'b1;

    if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;
    // Timeout wins over a busy-fall seen on the same edge.
    if (pop) begin
      rsp_valid_d = 1'b1;
      rsp_s_d     = timeout ? QNAN : div_s_i;
      rsp_err_d   = timeout;
      rsp_tag_d   = tag_mem[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      fdiv_q      <= 1'b0;
      ena_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_s_q     <= '0;
      rsp_tag_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      timer_q     <= timer_d;
      fdiv_q      <= fdiv_d;
      ena_q       <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_s_q     <= rsp_s_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      a_mem[wr_ptr_q]   <= req_a_i;
      b_mem[wr_ptr_q]   <= req_b_i;
      rm_mem[wr_ptr_q]  <= req_rm_i;
      tag_mem[wr_ptr_q] <= req_tag_i;
    end
  end

  assign div_a_o     = a_mem[rd_ptr_q];
  assign div_b_o     = b_mem[rd_ptr_q];
  assign div_rm_o    = rm_mem[rd_ptr_q];
  assign div_fdiv_o  = fdiv_q;
  assign div_ena_o   = ena_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_s_o     = rsp_s_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_err_o   = rsp_err_q;
  assign q_count_o   = count_q;

endmodule

// File: tb/tb_fdiv_issue_unit.sv
// Scoreboard bench for fdiv_issue_unit with a 12-cycle divider model keyed on operands.
module tb_fdiv_issue_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [1:0]  req_rm = '0;
  logic [3:0]  req_tag = '0;
  logic        rsp_valid, rsp_ready = 1'b1;
  logic [31:0] rsp_s;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [31:0] div_a, div_b;
  logic [1:0]  div_rm;
  logic        div_fdiv, div_ena;
  logic [31:0] div_s = '0;
  logic        div_busy = 1'b0;
  logic [1:0]  q_count;

  fdiv_issue_unit #(.DEPTH(2), .TAG_W(4), .TIMEOUT(64)) dut (
    .clk_i(clk), .clr_i(clr),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_rm_i(req_rm), .req_tag_i(req_tag),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_s_o(rsp_s), .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err),
    .div_a_o(div_a), .div_b_o(div_b), .div_rm_o(div_rm),
    .div_fdiv_o(div_fdiv), .div_ena_o(div_ena),
    .div_s_i(div_s), .div_busy_i(div_busy),
    .q_count_o(q_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] s;
    logic        err;
  } rsp_t;
  rsp_t sb[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=bound_expired exp=event", name);
  endtask

  // Divider model: hand-computed quotients; unknown operands give a poison value.
  function automatic logic [31:0] lut(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    if (a == 32'h41000000 && b == 32'h40800000) return 32'h40000000;
    if (a == 32'h3f800000 && b == 32'h40400000) return (rm == 2'd1 || rm == 2'd2) ? 32'h3eaaaaaa : 32'h3eaaaaab;
    if (a == 32'h0000fe01 && b == 32'h000000ff) return 32'h437f0000;
    return 32'hdeadbeef;
  endfunction

  logic m_started = 1'b0;
  logic m_stall   = 1'b0;
  int   m_cnt     = 0;

  always @(negedge clk) begin
    if (clr) begin
      m_started = 1'b0;
      div_busy  = 1'b0;
    end else if (!div_fdiv) begin
      m_started = 1'b0;
      div_busy  = 1'b0;
    end else if (!m_started) begin
      m_started = 1'b1;
      if (!m_stall) begin
        div_busy = 1'b1;
        m_cnt    = 12;
      end
    end else if (div_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        div_busy = 1'b0;
        div_s    = lut(div_a, div_b, div_rm);
      end
    end
  end

  // fdiv run/gap tracking and response-valid activity
  int hi_run = 0, lo_run = 0, last_hi = 0, last_gap = 0, hi_total = 0, rv_total = 0;
  logic fdiv_prev = 1'b0;

  always @(negedge clk) begin
    if (div_fdiv) begin
      if (!fdiv_prev) begin last_gap = lo_run; hi_run = 0; end
      hi_run++;
      hi_total++;
    end else begin
      if (fdiv_prev) begin last_hi = hi_run; lo_run = 0; end
      lo_run++;
    end
    fdiv_prev = div_fdiv;
    if (rsp_valid) rv_total++;
  end

  always @(negedge clk) begin
    rsp_t e;
    if (!clr && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got=tag %h s %h exp=none", rsp_tag, rsp_s);
      end else begin
        e = sb.pop_front();
        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
        chk("rsp_s",   rsp_s,        e.s);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                      input logic [3:0] tag, input logic [31:0] exp_s, input logic exp_err);
    int n = 0;
    @(negedge clk);
    req_a = a; req_b = b; req_rm = rm; req_tag = tag; req_valid = 1'b1;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) fail_bound("push_accept");
    else sb.push_back('{tag: tag, s: exp_s, err: exp_err});
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin @(posedge clk); n++; end
    if (sb.size() != 0) fail_bound("rsp_wait");
    @(posedge clk); #1;
  endtask

  logic [31:0] va [4] = '{32'h41000000, 32'h3f800000, 32'h0000fe01, 32'h3f800000};
  logic [31:0] vb [4] = '{32'h40800000, 32'h40400000, 32'h000000ff, 32'h40400000};
  logic [1:0]  vr [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [31:0] vs [4] = '{32'h40000000, 32'h3eaaaaaa, 32'h437f0000, 32'h3eaaaaab};

  initial begin
    int n;
    int snap;
    #2 clr = 1'b1;
    #1;
    chk("rst_fdiv",      32'(div_fdiv),  0);
    chk("rst_ena",       32'(div_ena),   0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_s",     rsp_s,          0);
    chk("rst_rsp_tag",   32'(rsp_tag),   0);
    chk("rst_rsp_err",   32'(rsp_err),   0);
    chk("rst_q_count",   32'(q_count),   0);
    chk("rst_req_ready", 32'(req_ready), 1);
    repeat (2) @(posedge clk);
    #2 clr = 1'b0;
    @(posedge clk); #1;
    chk("ena_after_rst", 32'(div_ena), 1);

    // basic divide: 8/4
    push(32'h41000000, 32'h40800000, 2'd0, 4'd3, 32'h40000000, 1'b0);
    wait_rsp(100);
    chk("basic_fdiv_len", last_hi, 13);

    // queue order and gap
    push(32'h3f800000, 32'h40400000, 2'd0, 4'd1, 32'h3eaaaaab, 1'b0);
    push(32'h0000fe01, 32'h000000ff, 2'd0, 4'd2, 32'h437f0000, 1'b0);
    chk("full_q_count",   32'(q_count),   2);
    chk("full_req_ready", 32'(req_ready), 0);
    wait_rsp(200);
    chk("gap_ge1", 32'(last_gap >= 1), 1);

    // response backpressure
    rsp_ready = 1'b0;
    push(32'h41000000, 32'h40800000, 2'd0, 4'd5, 32'h40000000, 1'b0);
    push(32'h3f800000, 32'h40400000, 2'd0, 4'd6, 32'h3eaaaaab, 1'b0);
    n = 0;
    while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!rsp_valid) fail_bound("bp_rsp_valid");
    snap = hi_total;
    repeat (20) @(posedge clk);
    #1;
    chk("bp_no_issue",  hi_total - snap,  0);
    chk("bp_fdiv",      32'(div_fdiv),    0);
    chk("bp_q_count",   32'(q_count),     1);
    chk("bp_rsp_valid", 32'(rsp_valid),   1);
    chk("bp_rsp_s",     rsp_s,            32'h40000000);
    chk("bp_rsp_tag",   32'(rsp_tag),     5);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_issue", 32'(div_fdiv), 1);
    wait_rsp(100);

    // timeout
    m_stall = 1'b1;
    push(32'h41000000, 32'h40800000, 2'd0, 4'd7, 32'h7fc00000, 1'b1);
    wait_rsp(200);
    chk("to_fdiv_len", last_hi,         64);
    chk("to_q_count",  32'(q_count),    0);
    m_stall = 1'b0;
    push(32'h0000fe01, 32'h000000ff, 2'd0, 4'd8, 32'h437f0000, 1'b0);
    wait_rsp(100);
    chk("after_to_fdiv_len", last_hi, 13);

    // reset mid-division with two entries queued
    push(32'h41000000, 32'h40800000, 2'd0, 4'd9,  32'h40000000, 1'b0);
    push(32'h0000fe01, 32'h000000ff, 2'd0, 4'd10, 32'h437f0000, 1'b0);
    n = 0;
    while (!div_busy && n < 50) begin @(posedge clk); #1; n++; end
    if (!div_busy) fail_bound("rst_wait_busy");
    chk("pre_rst_q_count", 32'(q_count), 2);
    repeat (3) @(posedge clk);
    #3 clr = 1'b1;
    #1;
    chk("mid_rst_fdiv",      32'(div_fdiv),  0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_q_count",   32'(q_count),   0);
    sb.delete();
    snap = rv_total;
    @(posedge clk);
    #2 clr = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_no_rsp",  rv_total - snap, 0);
    chk("post_rst_fdiv",    32'(div_fdiv),   0);
    chk("post_rst_q_count", 32'(q_count),    0);

    // simultaneous push/pop at completion, pointer wrap over 8 requests
    push(va[0], vb[0], vr[0], 4'd8, vs[0], 1'b0);
    for (int i = 1; i < 8; i++) begin
      n = 0;
      do begin @(negedge clk); #2; n++; end
      while (!(div_fdiv && m_started && !div_busy) && n < 100);
      if (n >= 100) fail_bound("pp_wait_done");
      req_a = va[i % 4]; req_b = vb[i % 4]; req_rm = vr[i % 4];
      req_tag = 4'(8 + i); req_valid = 1'b1;
      sb.push_back('{tag: 4'(8 + i), s: vs[i % 4], err: 1'b0});
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("pp_q_count",   32'(q_count),   1);
      chk("pp_rsp_valid", 32'(rsp_valid), 1);
    end
    wait_rsp(100);
    chk("final_q_count", 32'(q_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fdiv_issue_unit.md
# fdiv_issue_unit

Request-queue and sequencing stage placed directly upstream of the Newton-iteration float divider. It buffers single-precision divide requests from the FP pipeline with a valid/ready handshake and issues them one at a time to the divider. It holds the operands and `fdiv` steady for the whole iteration, captures the quotient when the divider goes idle, and returns it tagged on a valid/ready response port. It also aborts and flags any division that exceeds a cycle budget.

## Interface
- `DEPTH`, 2 — request FIFO entries; power of 2, ≥2.
- `TAG_W`, 4 — request/response tag width.
- `TIMEOUT`, 64 — maximum cycles an issued division may remain outstanding; must be ≥2.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `clr`  in  1  — asynchronous, active-high reset.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — `count < DEPTH`; no pass-through when full.
- `req_a`, `req_b`  in  32  — dividend and divisor, IEEE-754 single.
- `req_rm`  in  2  — rounding mode.
- `req_tag`  in  TAG_W  — returned unchanged on the response.
- `rsp_valid`  out  1  — response register holds a result.
- `rsp_ready`  in  1  — consumer accepts the response.
- `rsp_s`  out  32  — quotient.
- `rsp_tag`  out  TAG_W  — tag of the completed request.
- `rsp_err`  out  1  — 1 means the division timed out; `rsp_s` = 32'h7fc00000.
- `div_a`, `div_b`  out  32  — FIFO head operands, combinational.
- `div_rm`  out  2  — FIFO head rounding mode, combinational.
- `div_fdiv`  out  1  — registered start/hold to the divider.
- `div_ena`  out  1  — registered; 0 in reset, 1 from the first edge after `clr` deasserts.
- `div_s`  in  32  — divider result.
- `div_busy`  in  1  — divider iterating.
- `q_count`  out  log2(DEPTH)+1  — FIFO occupancy.

## Operation
- **FIFO:** circular buffer with read/write pointers that wrap at `DEPTH`.
  - Push on `req_valid & req_ready`.
  - Pop only at completion or abort.
  - A push and a pop in the same cycle leave the count unchanged.
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:** `div_fdiv` = 0.
  - Condition to go to ISSUE: `q_count` ≠ 0 AND (`rsp_valid` = 0 OR `rsp_ready` = 1).
  - When the condition holds, set `div_fdiv` = 1, clear the timer, and go to ISSUE.
- **ISSUE:** `div_fdiv` held at 1.
  - `div_busy` = 1 → go to WAIT.
- **WAIT:** `div_fdiv` held at 1.
  - `div_busy` = 0 → load `rsp_s` = `div_s`, `rsp_tag` = head tag, `rsp_err` = 0.
  - In the same step: set `rsp_valid`, pop the FIFO, drop `div_fdiv`, go to IDLE.
- **Timer:** increments every cycle in ISSUE or WAIT.
  - On reaching `TIMEOUT - 1` in either state, abort: load `rsp_s` = 32'h7fc00000, `rsp_err` = 1, the head tag, and set `rsp_valid`.
  - Then pop, drop `div_fdiv`, go to IDLE.
  - Timeout takes priority over a same-cycle busy-fall.
- **Response register:** `rsp_valid` clears on `rsp_valid & rsp_ready` unless reloaded in the same cycle.
  - Only one division is ever outstanding, and issue requires a free or draining slot, so a completion never overwrites an unconsumed result.
- **Operand stability:** `div_a`, `div_b`, `div_rm` come from the FIFO head, so they are stable from issue until pop.
- **Back-to-back issue:** `div_fdiv` is always low for at least one cycle (IDLE) between two divisions.
- **Reset:** asynchronous, and valid mid-operation. The FIFO empties, the FSM goes to IDLE, and any in-flight division is discarded with no response.
  - Reset values: `div_fdiv` = 0, `div_ena` = 0, `rsp_valid` = 0, `rsp_s` = 0, `rsp_tag` = 0, `rsp_err` = 0, `q_count` = 0, `req_ready` = 1.

## Timing
- Request accepted at edge E0.
  - Entry is visible at E0 and `q_count` increments.
  - With an idle FSM and free response slot, `div_fdiv` rises at E1.
- Busy seen low in WAIT at edge En: `rsp_valid` = 1 and `div_fdiv` = 0 after En.
  - The next queued request can raise `div_fdiv` at En+1.
- Overhead beyond divider latency:
  - 1 cycle, FIFO to issue.
  - 1 cycle, busy-fall to response.
- A stalled consumer (`rsp_ready` = 0 with `rsp_valid` = 1) blocks issue. The FIFO keeps accepting until full.

## Test plan
- **Basic divide:** bench divider model has 12-cycle busy.
  - Stimulus: `req_a` = 41000000, `req_b` = 40800000, `rm` = 0, tag = 3.
  - Required: `rsp_s` = 40000000, tag 3, `rsp_err` = 0, `div_fdiv` held high for exactly ISSUE+WAIT.
- **Queue order and gap:** push 3f800000/40400000 (tag 1) then 0000fe01/000000ff (tag 2) on consecutive cycles.
  - Required: `q_count` reaches 2 and `req_ready` = 0.
  - Required: responses tags 1 then 2, `rsp_s` = 3eaaaaab first; `div_fdiv` low for ≥1 cycle between them.
- **Response backpressure:** hold `rsp_ready` = 0 after the first result.
  - Required: the second request stays queued, `div_fdiv` stays 0, and `rsp_s` is stable.
  - Release `rsp_ready`: the second issue starts the next cycle.
- **Timeout:** model never raises busy, `TIMEOUT` = 64.
  - Required: after 64 cycles, `rsp_err` = 1, `rsp_s` = 7fc00000, correct tag, FIFO popped, and the next request issues normally.
- **Reset mid-division:** assert `clr` during WAIT with 2 entries queued.
  - Required: `div_fdiv`, `rsp_valid`, `q_count` all 0 immediately (asynchronously), and no response emitted afterward.
- **Simultaneous push/pop:** at completion with `q_count` = 1, push a new request in the same cycle.
  - Required: `q_count` stays 1, with correct pointer wrap over ≥3·`DEPTH` requests.
